// File: rtl/stopwatch_timer_dp.sv
// stopwatch_timer_dp: up-counting stopwatch / down-counting timer datapath with preset load, lap capture and terminal pulses
module stopwatch_timer_dp #(
    parameter int CLK_HZ = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int HOUR_MAX = 24,
    localparam int DIV = CLK_HZ / TICK_HZ,
    localparam int MS_W = $clog2(TICK_HZ),
    localparam int HR_W = $clog2(HOUR_MAX)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run_stop,
    input  logic            clear,
    input  logic            mode,
    input  logic            load,
    input  logic [MS_W-1:0] ld_msec,
    input  logic [5:0]      ld_sec,
    input  logic [5:0]      ld_min,
    input  logic [HR_W-1:0] ld_hour,
    input  logic            lap,
    output logic [MS_W-1:0] msec,
    output logic [5:0]      sec,
    output logic [5:0]      min,
    output logic [HR_W-1:0] hour,
    output logic [MS_W-1:0] lap_msec,
    output logic [5:0]      lap_sec,
    output logic [5:0]      lap_min,
    output logic [HR_W-1:0] lap_hour,
    output logic            lap_valid,
    output logic            rollover,
    output logic            done
);
    localparam int PS_W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_TOP = PS_W'(DIV - 1);
    localparam logic [MS_W-1:0] MS_TOP = MS_W'(TICK_HZ - 1);
    localparam logic [5:0]      SX_TOP = 6'd59;
    localparam logic [HR_W-1:0] HR_TOP = HR_W'(HOUR_MAX - 1);

    logic [PS_W-1:0] ps;
    logic            tick_en;
    logic            ms_c, sec_c, min_c, hr_c, ms_z, sec_z, min_z, hr_z;
    logic            at_max, at_zero, dn_zero;
    logic [MS_W-1:0] ms_up, ms_dn;
    logic [5:0]      sec_up, sec_dn, min_up, min_dn;
    logic [HR_W-1:0] hr_up, hr_dn;

    assign tick_en = run_stop && ps == PS_TOP;
    assign ms_c    = msec == MS_TOP;
    assign sec_c   = sec == SX_TOP;
    assign min_c   = min == SX_TOP;
    assign hr_c    = hour == HR_TOP;
    assign ms_z    = msec == '0;
    assign sec_z   = sec == '0;
    assign min_z   = min == '0;
    assign hr_z    = hour == '0;
    assign at_max  = ms_c && sec_c && min_c && hr_c;
    assign at_zero = ms_z && sec_z && min_z && hr_z;

    // every field's successor is formed in parallel so all digits change on one edge
    assign ms_up  = ms_c ? '0 : msec + 1'b1;
    assign sec_up = !ms_c ? sec : sec_c ? '0 : sec + 1'b1;
    assign min_up = !(ms_c && sec_c) ? min : min_c ? '0 : min + 1'b1;
    assign hr_up  = !(ms_c && sec_c && min_c) ? hour : hr_c ? '0 : hour + 1'b1;
    assign ms_dn  = ms_z ? MS_TOP : msec - 1'b1;
    assign sec_dn = !ms_z ? sec : sec_z ? SX_TOP : sec - 1'b1;
    assign min_dn = !(ms_z && sec_z) ? min : min_z ? SX_TOP : min - 1'b1;
    assign hr_dn  = !(ms_z && sec_z && min_z) ? hour : hr_z ? HR_TOP : hour - 1'b1;
    assign dn_zero = {ms_dn, sec_dn, min_dn, hr_dn} == '0;

    // prescaler: runs only while enabled so a pause keeps its phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ps <= '0;
        else if (clear || load || tick_en)
            ps <= '0;
        else if (run_stop)
            ps <= ps + 1'b1;
    end

    // time fields and terminal pulses: clear beats load beats tick; a zero timer ignores ticks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {msec, sec, min, hour} <= '0;
            rollover <= 1'b0;
            done <= 1'b0;
        end else begin
            rollover <= 1'b0;
            done <= 1'b0;
            if (clear) begin
                {msec, sec, min, hour} <= '0;
            end else if (load) begin
                msec <= ld_msec > MS_TOP ? MS_TOP : ld_msec;
                sec <= ld_sec > SX_TOP ? SX_TOP : ld_sec;
                min <= ld_min > SX_TOP ? SX_TOP : ld_min;
                hour <= ld_hour > HR_TOP ? HR_TOP : ld_hour;
            end else if (tick_en && !mode) begin
                {msec, sec, min, hour} <= {ms_up, sec_up, min_up, hr_up};
                rollover <= at_max;
            end else if (tick_en && !at_zero) begin
                {msec, sec, min, hour} <= {ms_dn, sec_dn, min_dn, hr_dn};
                done <= dn_zero;
            end
        end
    end

    // lap capture takes the pre-edge time; clear overrides a coincident lap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {lap_msec, lap_sec, lap_min, lap_hour} <= '0;
            lap_valid <= 1'b0;
        end else if (clear) begin
            {lap_msec, lap_sec, lap_min, lap_hour} <= '0;
            lap_valid <= 1'b0;
        end else if (lap) begin
            {lap_msec, lap_sec, lap_min, lap_hour} <= {msec, sec, min, hour};
            lap_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stopwatch_timer_dp.sv
// tb_stopwatch_timer_dp: directed and randomized checks of stopwatch_timer_dp against a total-count time model
module tb_stopwatch_timer_dp;
    localparam int CLK_HZ = 100;
    localparam int TICK_HZ = 10;
    localparam int HOUR_MAX = 24;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int MS_W = $clog2(TICK_HZ);
    localparam int HR_W = $clog2(HOUR_MAX);
    localparam int FW = MS_W + 12 + HR_W;
    localparam int VW = 2 * FW + 3;
    localparam int TOTAL = HOUR_MAX * 3600 * TICK_HZ;

    logic            clk = 1'b0, reset_n = 1'b0;
    logic            run_stop = 1'b0, clear = 1'b0, mode = 1'b0, load = 1'b0, lap = 1'b0;
    logic [MS_W-1:0] ld_msec = '0;
    logic [5:0]      ld_sec = '0, ld_min = '0;
    logic [HR_W-1:0] ld_hour = '0;
    logic [MS_W-1:0] msec, lap_msec;
    logic [5:0]      sec, min, lap_sec, lap_min;
    logic [HR_W-1:0] hour, lap_hour;
    logic            lap_valid, rollover, done;
    logic [VW-1:0]   obs_vec;
    int n_pass = 0, n_total = 0;
    int m_ps = 0, m_t = 0, m_lap = 0;
    logic m_lv = 1'b0, m_roll = 1'b0, m_done = 1'b0;

    stopwatch_timer_dp #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .HOUR_MAX(HOUR_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .run_stop(run_stop), .clear(clear), .mode(mode),
        .load(load), .ld_msec(ld_msec), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour),
        .lap(lap), .msec(msec), .sec(sec), .min(min), .hour(hour),
        .lap_msec(lap_msec), .lap_sec(lap_sec), .lap_min(lap_min), .lap_hour(lap_hour),
        .lap_valid(lap_valid), .rollover(rollover), .done(done)
    );

    always #5 clk = ~clk;

    assign obs_vec = {msec, sec, min, hour, lap_msec, lap_sec, lap_min, lap_hour, lap_valid, rollover, done};

    // time kept as a single count of sub-second ticks since 00:00:00.0
    function automatic logic [FW-1:0] fields(int t);
        return {MS_W'(t % TICK_HZ), 6'((t / TICK_HZ) % 60), 6'((t / (TICK_HZ * 60)) % 60),
                HR_W'(t / (TICK_HZ * 3600))};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {fields(m_t), fields(m_lap), m_lv, m_roll, m_done};
    endfunction

    function automatic int clamp(int v, int top);
        return v > top ? top : v;
    endfunction

    task automatic cycle();
        int nps = m_ps, nt = m_t, nlap = m_lap;
        logic nlv = m_lv, nroll = 1'b0, ndone = 1'b0;
        logic tick = run_stop && m_ps == DIV - 1;
        if (clear) begin
            nt = 0;
            nps = 0;
        end else if (load) begin
            nt = ((clamp(ld_hour, HOUR_MAX - 1) * 60 + clamp(ld_min, 59)) * 60 + clamp(ld_sec, 59)) * TICK_HZ
                 + clamp(ld_msec, TICK_HZ - 1);
            nps = 0;
        end else begin
            if (run_stop) nps = tick ? 0 : m_ps + 1;
            if (tick && !mode) begin
                nt = (m_t + 1) % TOTAL;
                nroll = nt == 0;
            end else if (tick && m_t != 0) begin
                nt = m_t - 1;
                ndone = nt == 0;
            end
        end
        if (clear) begin
            nlap = 0;
            nlv = 1'b0;
        end else if (lap) begin
            nlap = m_t;
            nlv = 1'b1;
        end
        @(posedge clk);
        {m_ps, m_t, m_lap, m_lv, m_roll, m_done} = {nps, nt, nlap, nlv, nroll, ndone};
        #1;
    endtask

    task automatic do_load(int ms, int s, int mi, int h);
        {ld_msec, ld_sec, ld_min, ld_hour} = {MS_W'(ms), 6'(s), 6'(mi), HR_W'(h)};
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if (obs_vec !== '0) $display("FAIL reset_state: outputs=%h expected 0", obs_vec); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_up();
        mode = 1'b0;
        do_clear();
        run_stop = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            cycle();
            if (i == 9) begin
                n_total++;
                if (msec !== 0) $display("FAIL up_before_tick: msec=%0d expected 0", msec); else n_pass++;
            end
            if (i == 10) begin
                n_total++;
                if (msec !== 1) $display("FAIL up_first_tick: msec=%0d expected 1", msec); else n_pass++;
            end
        end
        n_total++;
        if ({sec, msec} !== {6'd1, MS_W'(0)}) $display("FAIL up_sec_carry: sec=%0d msec=%0d expected 1/0", sec, msec);
        else n_pass++;
        n_total++;
        if (obs_vec !== exp_vec()) $display("FAIL up_model: got %h expected %h", obs_vec, exp_vec()); else n_pass++;
    endtask

    task automatic test_pause();
        do_clear();
        run_stop = 1'b1;
        repeat (5) cycle();
        run_stop = 1'b0;
        repeat (20) cycle();
        n_total++;
        if (msec !== 0) $display("FAIL pause_hold: msec=%0d expected 0", msec); else n_pass++;
        run_stop = 1'b1;
        repeat (4) cycle();
        n_total++;
        if (msec !== 0) $display("FAIL pause_phase_early: msec=%0d expected 0", msec); else n_pass++;
        cycle();
        n_total++;
        if (msec !== 1) $display("FAIL pause_phase: msec=%0d expected 1", msec); else n_pass++;
    endtask

    task automatic test_rollover();
        mode = 1'b0;
        run_stop = 1'b1;
        do_load(9, 59, 59, 23);
        repeat (9) cycle();
        n_total++;
        if ({msec, sec, min, hour, rollover} !== {MS_W'(9), 6'd59, 6'd59, HR_W'(23), 1'b0})
            $display("FAIL roll_max: fields=%0d/%0d/%0d/%0d roll=%b expected 9/59/59/23 0", msec, sec, min, hour, rollover);
        else n_pass++;
        cycle();
        n_total++;
        if ({msec, sec, min, hour, rollover} !== {{FW{1'b0}}, 1'b1})
            $display("FAIL roll_wrap: fields=%0d/%0d/%0d/%0d roll=%b expected 0 1", msec, sec, min, hour, rollover);
        else n_pass++;
        cycle();
        n_total++;
        if (rollover !== 1'b0) $display("FAIL roll_pulse: rollover=%b expected 0", rollover); else n_pass++;
    endtask

    task automatic test_done();
        int dones = 0;
        mode = 1'b1;
        run_stop = 1'b1;
        do_load(0, 1, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            cycle();
            dones += int'(done);
        end
        n_total++;
        if ({msec, sec, min, hour, done} !== {{FW{1'b0}}, 1'b1})
            $display("FAIL done_hit: fields=%0d/%0d/%0d/%0d done=%b expected 0 1", msec, sec, min, hour, done);
        else n_pass++;
        n_total++;
        if (dones !== 1) $display("FAIL done_count: pulses=%0d expected 1", dones); else n_pass++;
        dones = 0;
        repeat (200) begin
            cycle();
            dones += int'(done);
        end
        n_total++;
        if (dones !== 0 || {msec, sec, min, hour} !== '0)
            $display("FAIL done_hold: pulses=%0d fields=%0d/%0d/%0d/%0d expected 0 and zero", dones, msec, sec, min, hour);
        else n_pass++;
    endtask

    task automatic test_lap();
        mode = 1'b0;
        run_stop = 1'b0;
        do_clear();
        run_stop = 1'b1;
        repeat (49) cycle();
        lap = 1'b1;
        cycle();
        lap = 1'b0;
        n_total++;
        if ({lap_msec, msec, lap_valid} !== {MS_W'(4), MS_W'(5), 1'b1})
            $display("FAIL lap_pre_tick: lap_msec=%0d msec=%0d valid=%b expected 4 5 1", lap_msec, msec, lap_valid);
        else n_pass++;
        clear = 1'b1;
        lap = 1'b1;
        cycle();
        {clear, lap} = 2'b00;
        n_total++;
        if (lap_valid !== 1'b0 || {msec, sec, min, hour} !== '0)
            $display("FAIL lap_clear: valid=%b msec=%0d expected 0 0", lap_valid, msec);
        else n_pass++;
    endtask

    task automatic test_clamp_reset();
        mode = 1'b0;
        run_stop = 1'b0;
        do_load(15, 63, 0, 0);
        n_total++;
        if ({msec, sec} !== {MS_W'(9), 6'd59}) $display("FAIL load_clamp: msec=%0d sec=%0d expected 9 59", msec, sec);
        else n_pass++;
        run_stop = 1'b1;
        repeat (7) cycle();
        #3;
        reset_n = 1'b0;
        #1;
        {m_ps, m_t, m_lap, m_lv, m_roll, m_done} = '0;
        n_total++;
        if (obs_vec !== '0) $display("FAIL async_reset: outputs=%h expected 0", obs_vec); else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (9) cycle();
        n_total++;
        if (msec !== 0) $display("FAIL reset_phase_early: msec=%0d expected 0", msec); else n_pass++;
        cycle();
        n_total++;
        if (msec !== 1) $display("FAIL reset_phase: msec=%0d expected 1", msec); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            clear = ($urandom % 64) == 0;
            load = ($urandom % 24) == 0;
            lap = ($urandom % 12) == 0;
            run_stop = ($urandom % 8) != 0;
            if ($urandom % 40 == 0) mode = ~mode;
            case ($urandom % 3)
                0: {ld_msec, ld_sec, ld_min, ld_hour} = {MS_W'($urandom_range(15, 0)), 6'($urandom_range(2, 0)), 6'd0, HR_W'(0)};
                1: {ld_msec, ld_sec, ld_min, ld_hour} = {MS_W'($urandom_range(9, 5)), 6'd59, 6'd59, HR_W'(23)};
                default: {ld_msec, ld_sec, ld_min, ld_hour} = FW'($urandom);
            endcase
            cycle();
            n_total++;
            if (obs_vec !== exp_vec()) $display("FAIL random_%0d: got %h expected %h", i, obs_vec, exp_vec());
            else n_pass++;
        end
        {clear, load, lap} = 3'b000;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_pause();
        test_rollover();
        test_done();
        test_lap();
        test_clamp_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
